// File: rtl/bot_multi_if.sv
// Purpose : PicoBlaze register interface serving NUM_BOTS Rojobot channels from one
//           I/O port space, with atomic snapshot loads and an acked update-irq per channel.
// Latency : read data is registered, valid 1 clk after AddrIn; writes take effect on the next edge.
// Backpr. : none; the PicoBlaze strobes are single-cycle and always accepted.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   Wr_Strobe, Rd_Strobe, AddrIn[7:4]=channel, AddrIn[3:0]=register, DataIn, DataOut
//   MotCtl, BotConfig   per-channel inputs, channel k at [8k+7:8k]
//   LocX, LocY, BotInfo, Sensors   per-channel user-visible snapshots
//   MapX, MapY, MapVal  shared world-map address / value
//   upd_irq, upd_ack    per-channel sticky update interrupt and its acknowledge
module bot_multi_if #(
    parameter int unsigned NUM_BOTS         = 2,
    parameter logic [7:0]  START_LOCATION_X = 8'h00,
    parameter logic [7:0]  START_LOCATION_Y = 8'h00,
    parameter logic [7:0]  IF_VERSION       = 8'h40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Wr_Strobe,
    input  logic                    Rd_Strobe,
    input  logic [7:0]              AddrIn,
    input  logic [7:0]              DataIn,
    output logic [7:0]              DataOut,
    input  logic [8*NUM_BOTS-1:0]   MotCtl,
    input  logic [8*NUM_BOTS-1:0]   BotConfig,
    output logic [8*NUM_BOTS-1:0]   LocX,
    output logic [8*NUM_BOTS-1:0]   LocY,
    output logic [8*NUM_BOTS-1:0]   BotInfo,
    output logic [8*NUM_BOTS-1:0]   Sensors,
    output logic [7:0]              MapX,
    output logic [7:0]              MapY,
    input  logic [1:0]              MapVal,
    output logic [NUM_BOTS-1:0]     upd_irq,
    input  logic [NUM_BOTS-1:0]     upd_ack
);

    // Read path is purely address driven; the read strobe carries no information here.
    logic unused_rd_strobe;
    assign unused_rd_strobe = Rd_Strobe;

    logic [3:0] chan;
    logic [3:0] rsel;
    logic       chan_valid;

    assign chan       = AddrIn[7:4];
    assign rsel       = AddrIn[3:0];
    assign chan_valid = ({1'b0, chan} < 5'(NUM_BOTS));

    // Internal (PicoBlaze side) registers
    logic [7:0] locx_int_q [NUM_BOTS];
    logic [7:0] locx_int_d [NUM_BOTS];
    logic [7:0] locy_int_q [NUM_BOTS];
    logic [7:0] locy_int_d [NUM_BOTS];
    logic [7:0] info_int_q [NUM_BOTS];
    logic [7:0] info_int_d [NUM_BOTS];
    logic [7:0] sens_int_q [NUM_BOTS];
    logic [7:0] sens_int_d [NUM_BOTS];

    // User-visible snapshots
    logic [7:0] locx_out_q [NUM_BOTS];
    logic [7:0] locx_out_d [NUM_BOTS];
    logic [7:0] locy_out_q [NUM_BOTS];
    logic [7:0] locy_out_d [NUM_BOTS];
    logic [7:0] info_out_q [NUM_BOTS];
    logic [7:0] info_out_d [NUM_BOTS];
    logic [7:0] sens_out_q [NUM_BOTS];
    logic [7:0] sens_out_d [NUM_BOTS];

    logic [7:0] miss_cnt_q [NUM_BOTS];
    logic [7:0] miss_cnt_d [NUM_BOTS];

    logic [NUM_BOTS-1:0] upd_irq_q;
    logic [NUM_BOTS-1:0] upd_irq_d;

    logic [7:0] map_x_q;
    logic [7:0] map_x_d;
    logic [7:0] map_y_q;
    logic [7:0] map_y_d;
    logic [7:0] data_out_q;
    logic [7:0] data_out_d;

    // Next-state logic for every write-side register.
    always_comb begin
        locx_int_d = locx_int_q;
        locy_int_d = locy_int_q;
        info_int_d = info_int_q;
        sens_int_d = sens_int_q;
        locx_out_d = locx_out_q;
        locy_out_d = locy_out_q;
        info_out_d = info_out_q;
        sens_out_d = sens_out_q;
        miss_cnt_d = miss_cnt_q;
        upd_irq_d  = upd_irq_q;
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;

        // Map address is shared by all channels
        if (Wr_Strobe && chan_valid) begin
            if (rsel == 4'h8) map_x_d = DataIn;
            if (rsel == 4'h9) map_y_d = DataIn;
        end

        for (int k = 0; k < NUM_BOTS; k++) begin
            logic wr_k;
            logic raise_k;
            logic clr_k;
            wr_k    = Wr_Strobe && (chan == 4'(k));
            raise_k = wr_k && (rsel == 4'hE);
            clr_k   = wr_k && (rsel == 4'hB);

            if (wr_k) begin
                case (rsel)
                    4'h1: locx_int_d[k] = DataIn;
                    4'h2: locy_int_d[k] = DataIn;
                    4'h3: info_int_d[k] = DataIn;
                    4'h4: sens_int_d[k] = DataIn;
                    4'hC: begin
                        // Snapshot copies the registered values, so a same-edge
                        // internal write is never seen by this load.
                        locx_out_d[k] = locx_int_q[k];
                        locy_out_d[k] = locy_int_q[k];
                        info_out_d[k] = info_int_q[k];
                        sens_out_d[k] = sens_int_q[k];
                    end
                    default: ;
                endcase
            end

            // Raise has priority over ack so a fresh update is never dropped.
            if (raise_k)
                upd_irq_d[k] = 1'b1;
            else if (upd_ack[k])
                upd_irq_d[k] = 1'b0;

            // A miss is a raise landing on a still-pending, unacknowledged irq.
            if (clr_k)
                miss_cnt_d[k] = 8'h00;
            else if (raise_k && upd_irq_q[k] && !upd_ack[k] && (miss_cnt_q[k] != 8'hFF))
                miss_cnt_d[k] = miss_cnt_q[k] + 8'd1;
        end
    end

    // Read mux; unmatched channels (>= NUM_BOTS) fall through to zero.
    always_comb begin
        data_out_d = 8'h00;
        for (int k = 0; k < NUM_BOTS; k++) begin
            if (chan == 4'(k)) begin
                case (rsel)
                    4'h0:    data_out_d = MotCtl[8*k +: 8];
                    4'h1:    data_out_d = locx_int_q[k];
                    4'h2:    data_out_d = locy_int_q[k];
                    4'h3:    data_out_d = info_int_q[k];
                    4'h4:    data_out_d = sens_int_q[k];
                    4'h7:    data_out_d = BotConfig[8*k +: 8];
                    4'h8:    data_out_d = map_x_q;
                    4'h9:    data_out_d = map_y_q;
                    4'hA:    data_out_d = {6'b000000, MapVal};
                    4'hB:    data_out_d = miss_cnt_q[k];
                    4'hF:    data_out_d = IF_VERSION;
                    default: data_out_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BOTS; k++) begin
                locx_int_q[k] <= START_LOCATION_X;
                locy_int_q[k] <= START_LOCATION_Y;
                info_int_q[k] <= 8'h00;
                sens_int_q[k] <= 8'h00;
                locx_out_q[k] <= 8'h00;
                locy_out_q[k] <= 8'h00;
                info_out_q[k] <= 8'h00;
                sens_out_q[k] <= 8'h00;
                miss_cnt_q[k] <= 8'h00;
            end
            upd_irq_q  <= '0;
            map_x_q    <= 8'h00;
            map_y_q    <= 8'h00;
            data_out_q <= 8'h00;
        end else begin
            locx_int_q <= locx_int_d;
            locy_int_q <= locy_int_d;
            info_int_q <= info_int_d;
            sens_int_q <= sens_int_d;
            locx_out_q <= locx_out_d;
            locy_out_q <= locy_out_d;
            info_out_q <= info_out_d;
            sens_out_q <= sens_out_d;
            miss_cnt_q <= miss_cnt_d;
            upd_irq_q  <= upd_irq_d;
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
            data_out_q <= data_out_d;
        end
    end

    // Pack per-channel snapshots onto the flat output buses.
    always_comb begin
        LocX    = '0;
        LocY    = '0;
        BotInfo = '0;
        Sensors = '0;
        for (int k = 0; k < NUM_BOTS; k++) begin
            LocX[8*k +: 8]    = locx_out_q[k];
            LocY[8*k +: 8]    = locy_out_q[k];
            BotInfo[8*k +: 8] = info_out_q[k];
            Sensors[8*k +: 8] = sens_out_q[k];
        end
    end

    assign DataOut = data_out_q;
    assign MapX    = map_x_q;
    assign MapY    = map_y_q;
    assign upd_irq = upd_irq_q;

endmodule

// File: tb/tb_bot_multi_if.sv
// Purpose : directed check of bot_multi_if (2 channels, START_LOCATION_X=8'h10, START_LOCATION_Y=8'h05).
// Latency : inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpr. : none; stimulus is free-running.
module tb_bot_multi_if;

    localparam int NB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            Wr_Strobe;
    logic            Rd_Strobe;
    logic [7:0]      AddrIn;
    logic [7:0]      DataIn;
    logic [7:0]      DataOut;
    logic [8*NB-1:0] MotCtl;
    logic [8*NB-1:0] BotConfig;
    logic [8*NB-1:0] LocX;
    logic [8*NB-1:0] LocY;
    logic [8*NB-1:0] BotInfo;
    logic [8*NB-1:0] Sensors;
    logic [7:0]      MapX;
    logic [7:0]      MapY;
    logic [1:0]      MapVal;
    logic [NB-1:0]   upd_irq;
    logic [NB-1:0]   upd_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    bot_multi_if #(
        .NUM_BOTS(NB),
        .START_LOCATION_X(8'h10),
        .START_LOCATION_Y(8'h05),
        .IF_VERSION(8'h40)
    ) dut (
        .clk(clk), .reset(reset),
        .Wr_Strobe(Wr_Strobe), .Rd_Strobe(Rd_Strobe),
        .AddrIn(AddrIn), .DataIn(DataIn), .DataOut(DataOut),
        .MotCtl(MotCtl), .BotConfig(BotConfig),
        .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .Sensors(Sensors),
        .MapX(MapX), .MapY(MapY), .MapVal(MapVal),
        .upd_irq(upd_irq), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] val;   // write data, or expected read data
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        AddrIn    = a;
        DataIn    = d;
        Wr_Strobe = 1'b1;
        @(negedge clk);
        Wr_Strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        AddrIn    = a;
        Wr_Strobe = 1'b0;
        Rd_Strobe = 1'b1;
        @(negedge clk);
        Rd_Strobe = 1'b0;
        d = DataOut;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(name, {24'h0, d}, {24'h0, exp});
    endtask

    initial begin
        logic [7:0] d;

        reset     = 1'b1;
        Wr_Strobe = 1'b0;
        Rd_Strobe = 1'b0;
        AddrIn    = 8'h00;
        DataIn    = 8'h00;
        MotCtl    = 16'hB2A1;
        BotConfig = 16'h7C3E;
        MapVal    = 2'b10;
        upd_ack   = '0;

        repeat (3) @(negedge clk);
        check("rst_dataout", {24'h0, DataOut}, 32'h0);
        check("rst_locx",    {16'h0, LocX},    32'h0);
        check("rst_locy",    {16'h0, LocY},    32'h0);
        check("rst_info",    {16'h0, BotInfo}, 32'h0);
        check("rst_sens",    {16'h0, Sensors}, 32'h0);
        check("rst_irq",     {30'h0, upd_irq}, 32'h0);
        check("rst_mapxy",   {16'h0, MapX, MapY}, 32'h0);
        reset = 1'b0;

        // Single-cycle register behaviour
        vecs = '{
            '{0, 8'h01, 8'h10}, '{0, 8'h02, 8'h05}, '{0, 8'h11, 8'h10},
            '{0, 8'h00, 8'hA1}, '{0, 8'h10, 8'hB2}, '{0, 8'h07, 8'h3E},
            '{0, 8'h17, 8'h7C}, '{0, 8'h0F, 8'h40}, '{0, 8'h3F, 8'h00},
            '{1, 8'h11, 8'h22}, '{1, 8'h12, 8'h33}, '{1, 8'h13, 8'h44},
            '{1, 8'h14, 8'h55},
            '{0, 8'h11, 8'h22}, '{0, 8'h14, 8'h55}, '{0, 8'h01, 8'h10},
            '{1, 8'h31, 8'h99}, '{0, 8'h31, 8'h00}, '{0, 8'h01, 8'h10},
            '{0, 8'h11, 8'h22},
            '{1, 8'h08, 8'h5A}, '{1, 8'h19, 8'h6B},
            '{0, 8'h18, 8'h5A}, '{0, 8'h09, 8'h6B}, '{0, 8'h0A, 8'h02},
            '{0, 8'h05, 8'h00}, '{0, 8'h06, 8'h00}, '{0, 8'h0C, 8'h00},
            '{0, 8'h0D, 8'h00}, '{0, 8'h0E, 8'h00}, '{0, 8'h1B, 8'h00}
        };
        foreach (vecs[i]) begin
            if (vecs[i].is_wr)
                wr(vecs[i].addr, vecs[i].val);
            else
                rd_chk($sformatf("vec%0d_rd%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].val);
        end
        check("mapx_out", {24'h0, MapX}, 32'h5A);
        check("mapy_out", {24'h0, MapY}, 32'h6B);
        check("pre_snap_locx", {16'h0, LocX}, 32'h0);

        // Snapshot load on channel 1 only
        wr(8'h1C, 8'h00);
        check("snap_locx", {16'h0, LocX},    32'h2200);
        check("snap_locy", {16'h0, LocY},    32'h3300);
        check("snap_info", {16'h0, BotInfo}, 32'h4400);
        check("snap_sens", {16'h0, Sensors}, 32'h5500);
        // Later internal writes stay hidden until the next load
        wr(8'h11, 8'h77);
        check("snap_hold", {16'h0, LocX}, 32'h2200);
        wr(8'h0C, 8'h00);
        check("snap_ch0", {16'h0, LocX}, 32'h2210);
        check("snap_ch0y", {16'h0, LocY}, 32'h3305);

        // Update handshake on channel 0
        wr(8'h0E, 8'h00);
        check("irq_raise", {30'h0, upd_irq}, 32'h1);
        wr(8'h0E, 8'h00);
        wr(8'h0E, 8'h00);
        rd_chk("miss_two", 8'h0B, 8'h02);
        rd_chk("miss_ch1", 8'h1B, 8'h00);
        @(negedge clk); upd_ack = 2'b01;
        @(negedge clk); upd_ack = 2'b00;
        check("irq_acked", {30'h0, upd_irq}, 32'h0);
        wr(8'h0B, 8'h00);
        rd_chk("miss_clr", 8'h0B, 8'h00);

        // Raise and ack on the same edge with irq already pending
        wr(8'h0E, 8'h00);
        check("irq_re", {30'h0, upd_irq}, 32'h1);
        @(negedge clk);
        AddrIn = 8'h0E; Wr_Strobe = 1'b1; upd_ack = 2'b01;
        @(negedge clk);
        Wr_Strobe = 1'b0; upd_ack = 2'b00;
        check("irq_raise_ack", {30'h0, upd_irq}, 32'h1);
        rd_chk("miss_raise_ack", 8'h0B, 8'h00);

        // Saturation: strobe held for back-to-back raises
        @(negedge clk);
        AddrIn = 8'h0E; Wr_Strobe = 1'b1;
        repeat (254) @(negedge clk);
        Wr_Strobe = 1'b0;
        rd_chk("miss_fe", 8'h0B, 8'hFE);
        @(negedge clk);
        AddrIn = 8'h0E; Wr_Strobe = 1'b1;
        repeat (5) @(negedge clk);
        Wr_Strobe = 1'b0;
        rd_chk("miss_sat", 8'h0B, 8'hFF);
        check("irq_ch1_idle", {31'h0, upd_irq[1]}, 32'h0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_irq",  {30'h0, upd_irq}, 32'h0);
        check("arst_locx", {16'h0, LocX},    32'h0);
        check("arst_mapx", {24'h0, MapX},    32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("arst_locx_int", 8'h11, 8'h10);
        rd_chk("arst_miss",     8'h0B, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
